// File: rtl/uart_tx_arbiter_if.sv
// Handshake and byte bus between the two harts' IO store paths, the shared
// UART transmitter and the arbiter that sits between them.
interface uart_tx_arbiter_if;
   logic       a_wr;
   logic [7:0] a_wdata;
   logic       a_full;
   logic       a_ovf;
   logic       b_wr;
   logic [7:0] b_wdata;
   logic       b_full;
   logic       b_ovf;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_src;

   // Arbiter side
   modport slave (
      input  a_wr, a_wdata, b_wr, b_wdata, tx_ready,
      output a_full, a_ovf, b_full, b_ovf, tx_valid, tx_data, tx_src
   );

   // Hart / UART side
   modport master (
      output a_wr, a_wdata, b_wr, b_wdata, tx_ready,
      input  a_full, a_ovf, b_full, b_ovf, tx_valid, tx_data, tx_src
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between hart a and hart b. Each hart has a
// small byte FIFO; a round-robin arbiter (optionally holding the grant for
// a whole line) drains both into a single registered valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no lock held; round-robin between non-empty FIFOs
// LOCK_A  | hart a owns the UART until it sends 0x0A or times out
// LOCK_B  | hart b owns the UART until it sends 0x0A or times out
module uart_tx_arbiter #(
   parameter int DEPTH        = 16,
   parameter int LINE_LOCK    = 1,
   parameter int LOCK_TIMEOUT = 1024
) (
   input logic              clk,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   // Index 0 is hart a, index 1 is hart b.
   logic [1:0]    wr;
   logic [7:0]    wdata [2];
   logic [7:0]    mem_q [2][DEPTH];
   logic [AW-1:0] wptr_q [2];
   logic [AW-1:0] rptr_q [2];
   logic [CW-1:0] cnt_q [2];
   logic [1:0]    ovf_q;
   logic [1:0]    full;
   logic [1:0]    nempty;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [7:0]    head [2];

   state_t        state_q, state_d;
   logic          pref_q, pref_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_src_q, tx_src_d;

   logic          load_en;
   logic          grant_vld;
   logic          grant_src;
   logic          lock_x;

   assign wr       = {bus.b_wr, bus.a_wr};
   assign wdata[0] = bus.a_wdata;
   assign wdata[1] = bus.b_wdata;

   // Full/empty come from the registered count, so a write never reaches the
   // output stage in the cycle it is accepted and full lags a push by a cycle.
   always_comb begin
      for (int h = 0; h < 2; h++) begin
         full[h]   = (cnt_q[h] == CW'(DEPTH));
         nempty[h] = (cnt_q[h] != '0);
         push[h]   = wr[h] && !full[h];
         head[h]   = mem_q[h][rptr_q[h]];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int h = 0; h < 2; h++) begin
            wptr_q[h] <= '0;
            rptr_q[h] <= '0;
            cnt_q[h]  <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int h = 0; h < 2; h++) begin
            if (push[h]) wptr_q[h] <= wptr_q[h] + 1'b1;
            if (pop[h])  rptr_q[h] <= rptr_q[h] + 1'b1;
            if (push[h] && !pop[h])      cnt_q[h] <= cnt_q[h] + 1'b1;
            else if (!push[h] && pop[h]) cnt_q[h] <= cnt_q[h] - 1'b1;
            if (wr[h] && full[h]) ovf_q[h] <= 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care while the pointers are reset.
   always_ff @(posedge clk) begin
      for (int h = 0; h < 2; h++) begin
         if (push[h]) mem_q[h][wptr_q[h]] <= wdata[h];
      end
   end

   // The output register may take a new byte when empty or when its
   // current byte leaves in this very cycle.
   assign load_en = !tx_valid_q || bus.tx_ready;
   assign lock_x  = (state_q == LOCK_B);

   // Arbitration, lock tracking and output-register next state.
   always_comb begin
      state_d    = state_q;
      pref_d     = pref_q;
      tmo_d      = tmo_q;
      grant_vld  = 1'b0;
      grant_src  = 1'b0;
      pop        = '0;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      tx_src_d   = tx_src_q;

      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (load_en) begin
               if (nempty[0] && nempty[1]) begin
                  grant_vld = 1'b1;
                  grant_src = pref_q;
                  pref_d    = !pref_q;
               end else if (nempty[0]) begin
                  grant_vld = 1'b1;
                  grant_src = 1'b0;
               end else if (nempty[1]) begin
                  grant_vld = 1'b1;
                  grant_src = 1'b1;
               end
               if (LINE_LOCK != 0 && grant_vld && head[grant_src] != 8'h0A) begin
                  state_d = grant_src ? LOCK_B : LOCK_A;
               end
            end
         end

         LOCK_A, LOCK_B: begin
            if (nempty[lock_x]) begin
               tmo_d = '0;
               if (load_en) begin
                  grant_vld = 1'b1;
                  grant_src = lock_x;
                  if (head[lock_x] == 8'h0A) begin
                     state_d = IDLE;
                     pref_d  = !lock_x;
                  end
               end
            end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
               state_d = IDLE;
               pref_d  = !lock_x;
               tmo_d   = '0;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            tmo_d   = '0;
         end
      endcase

      pop[grant_src] = grant_vld;

      if (load_en) begin
         tx_valid_d = grant_vld;
         if (grant_vld) begin
            tx_data_d = head[grant_src];
            tx_src_d  = grant_src;
         end
      end
   end

   // Arbiter state, round-robin preference and lock timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pref_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         pref_q  <= pref_d;
         tmo_q   <= tmo_d;
      end
   end

   // Output register; a reset drops whatever byte is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_src_q   <= 1'b0;
      end else begin
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         tx_src_q   <= tx_src_d;
      end
   end

   assign bus.a_full   = full[0];
   assign bus.b_full   = full[1];
   assign bus.a_ovf    = ovf_q[0];
   assign bus.b_ovf    = ovf_q[1];
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_src   = tx_src_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a line-locking instance (timeout 8) and a pure
// round-robin instance driven by the same hart/UART stimulus, each with its
// own expected-byte queue checked at every transfer.
module tb_uart_tx_arbiter;

   logic       clk;
   logic       reset;
   logic       a_wr, b_wr, tx_ready;
   logic [7:0] a_wdata, b_wdata;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter_if if_l ();
   uart_tx_arbiter_if if_r ();

   assign if_l.a_wr = a_wr;   assign if_r.a_wr = a_wr;
   assign if_l.a_wdata = a_wdata; assign if_r.a_wdata = a_wdata;
   assign if_l.b_wr = b_wr;   assign if_r.b_wr = b_wr;
   assign if_l.b_wdata = b_wdata; assign if_r.b_wdata = b_wdata;
   assign if_l.tx_ready = tx_ready; assign if_r.tx_ready = tx_ready;

   uart_tx_arbiter #(.DEPTH(16), .LINE_LOCK(1), .LOCK_TIMEOUT(8)) dut_l (
      .clk(clk), .reset(reset), .bus(if_l)
   );
   uart_tx_arbiter #(.DEPTH(16), .LINE_LOCK(0), .LOCK_TIMEOUT(8)) dut_r (
      .clk(clk), .reset(reset), .bus(if_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       src;
   } exp_t;

   exp_t q_l[$];
   exp_t q_r[$];
   exp_t e_l, e_r;

   typedef struct {
      logic       a_wr;
      logic [7:0] a_wdata;
      logic       acc;
      logic       e_af, e_ao, e_bf, e_bo;
   } vec_t;

   vec_t tbl[18];

   logic [7:0] sa[3];
   logic [7:0] sb[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_both(input logic [7:0] d, input logic s);
      q_l.push_back('{d, s});
      q_r.push_back('{d, s});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_wr  = 1'b0;
      b_wr  = 1'b0;
      tick();
      reset = 1'b0;
      q_l.delete();
      q_r.delete();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q_l.size() != 0 || q_r.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_drain_lock_left"}, q_l.size(), 0);
      chk({name, "_drain_rr_left"}, q_r.size(), 0);
      repeat (5) tick();
   endtask

   // Scoreboard and hold-stability monitor, locked instance.
   logic       l_stall;
   logic [7:0] l_hd;
   logic       l_hs;
   always @(negedge clk) begin
      if (reset) begin
         l_stall = 1'b0;
      end else begin
         if (l_stall) begin
            checks++;
            if (!if_l.tx_valid || if_l.tx_data !== l_hd || if_l.tx_src !== l_hs) begin
               errors++;
               $display("FAIL lock_hold: actual v=%0b d=%02h s=%0b required v=1 d=%02h s=%0b",
                        if_l.tx_valid, if_l.tx_data, if_l.tx_src, l_hd, l_hs);
            end
         end
         if (if_l.tx_valid && if_l.tx_ready) begin
            checks++;
            if (q_l.size() == 0) begin
               errors++;
               $display("FAIL lock_xfer: actual d=%02h s=%0b required no transfer",
                        if_l.tx_data, if_l.tx_src);
            end else begin
               e_l = q_l.pop_front();
               if (if_l.tx_data !== e_l.data || if_l.tx_src !== e_l.src) begin
                  errors++;
                  $display("FAIL lock_xfer: actual d=%02h s=%0b required d=%02h s=%0b",
                           if_l.tx_data, if_l.tx_src, e_l.data, e_l.src);
               end
            end
         end
         l_stall = if_l.tx_valid && !if_l.tx_ready;
         l_hd    = if_l.tx_data;
         l_hs    = if_l.tx_src;
      end
   end

   // Scoreboard and hold-stability monitor, round-robin instance.
   logic       r_stall;
   logic [7:0] r_hd;
   logic       r_hs;
   always @(negedge clk) begin
      if (reset) begin
         r_stall = 1'b0;
      end else begin
         if (r_stall) begin
            checks++;
            if (!if_r.tx_valid || if_r.tx_data !== r_hd || if_r.tx_src !== r_hs) begin
               errors++;
               $display("FAIL rr_hold: actual v=%0b d=%02h s=%0b required v=1 d=%02h s=%0b",
                        if_r.tx_valid, if_r.tx_data, if_r.tx_src, r_hd, r_hs);
            end
         end
         if (if_r.tx_valid && if_r.tx_ready) begin
            checks++;
            if (q_r.size() == 0) begin
               errors++;
               $display("FAIL rr_xfer: actual d=%02h s=%0b required no transfer",
                        if_r.tx_data, if_r.tx_src);
            end else begin
               e_r = q_r.pop_front();
               if (if_r.tx_data !== e_r.data || if_r.tx_src !== e_r.src) begin
                  errors++;
                  $display("FAIL rr_xfer: actual d=%02h s=%0b required d=%02h s=%0b",
                           if_r.tx_data, if_r.tx_src, e_r.data, e_r.src);
               end
            end
         end
         r_stall = if_r.tx_valid && !if_r.tx_ready;
         r_hd    = if_r.tx_data;
         r_hs    = if_r.tx_src;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cl, cr;
      reset    = 1'b1;
      a_wr     = 1'b0;
      b_wr     = 1'b0;
      a_wdata  = 8'h00;
      b_wdata  = 8'h00;
      tx_ready = 1'b0;

      for (int r = 0; r < 18; r++) begin
         tbl[r].a_wr    = (r < 17);
         tbl[r].a_wdata = 8'(r);
         tbl[r].acc     = (r < 16);
         tbl[r].e_af    = (r >= 15);
         tbl[r].e_ao    = (r >= 16);
         tbl[r].e_bf    = 1'b0;
         tbl[r].e_bo    = 1'b0;
      end
      sa[0] = 8'h41; sa[1] = 8'h42; sa[2] = 8'h0A;
      sb[0] = 8'h78; sb[1] = 8'h79; sb[2] = 8'h0A;

      // Reset values and single-byte latency.
      do_reset();
      tx_ready = 1'b1;
      chk("rst_valid_l", if_l.tx_valid, 0);
      chk("rst_valid_r", if_r.tx_valid, 0);
      chk("rst_data_l", if_l.tx_data, 0);
      chk("rst_src_l", if_l.tx_src, 0);
      chk("rst_flags_l", {if_l.a_full, if_l.a_ovf, if_l.b_full, if_l.b_ovf}, 0);
      chk("rst_flags_r", {if_r.a_full, if_r.a_ovf, if_r.b_full, if_r.b_ovf}, 0);
      push_both(8'h41, 1'b0);
      a_wr = 1'b1; a_wdata = 8'h41;
      tick();
      a_wr = 1'b0;
      chk("lat_c1_valid_l", if_l.tx_valid, 0);
      chk("lat_c1_valid_r", if_r.tx_valid, 0);
      tick();
      chk("lat_c2_valid_l", if_l.tx_valid, 1);
      chk("lat_c2_data_l", if_l.tx_data, 8'h41);
      chk("lat_c2_src_l", if_l.tx_src, 0);
      chk("lat_c2_valid_r", if_r.tx_valid, 1);
      chk("lat_c2_data_r", if_r.tx_data, 8'h41);
      tick();
      chk("lat_c3_valid_l", if_l.tx_valid, 0);
      chk("lat_c3_valid_r", if_r.tx_valid, 0);
      drain("latency");

      // Two lines written together, sink stalling three cycles per byte.
      do_reset();
      tx_ready = 1'b0;
      q_l.push_back('{8'h41, 1'b0}); q_l.push_back('{8'h42, 1'b0});
      q_l.push_back('{8'h0A, 1'b0}); q_l.push_back('{8'h78, 1'b1});
      q_l.push_back('{8'h79, 1'b1}); q_l.push_back('{8'h0A, 1'b1});
      q_r.push_back('{8'h41, 1'b0}); q_r.push_back('{8'h78, 1'b1});
      q_r.push_back('{8'h42, 1'b0}); q_r.push_back('{8'h79, 1'b1});
      q_r.push_back('{8'h0A, 1'b0}); q_r.push_back('{8'h0A, 1'b1});
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               a_wr = 1'b1; a_wdata = sa[i];
               b_wr = 1'b1; b_wdata = sb[i];
               tick();
            end
            a_wr = 1'b0;
            b_wr = 1'b0;
         end
         begin
            for (int k = 0; k < 40; k++) begin
               tx_ready = ((k % 4) == 3);
               tick();
            end
            tx_ready = 1'b1;
         end
      join
      drain("lines");

      // Fill hart a behind a held output byte from hart b.
      do_reset();
      tx_ready = 1'b0;
      push_both(8'h0A, 1'b1);
      b_wr = 1'b1; b_wdata = 8'h0A;
      tick();
      b_wr = 1'b0;
      tick();
      tick();
      chk("hold_valid_l", if_l.tx_valid, 1);
      chk("hold_valid_r", if_r.tx_valid, 1);
      for (int r = 0; r < 18; r++) begin
         a_wr    = tbl[r].a_wr;
         a_wdata = tbl[r].a_wdata;
         if (tbl[r].acc) push_both(tbl[r].a_wdata, 1'b0);
         tick();
         chk($sformatf("row%0d_a_full_l", r), if_l.a_full, tbl[r].e_af);
         chk($sformatf("row%0d_a_ovf_l", r), if_l.a_ovf, tbl[r].e_ao);
         chk($sformatf("row%0d_b_flags_l", r), {if_l.b_full, if_l.b_ovf}, {tbl[r].e_bf, tbl[r].e_bo});
         chk($sformatf("row%0d_a_full_r", r), if_r.a_full, tbl[r].e_af);
         chk($sformatf("row%0d_a_ovf_r", r), if_r.a_ovf, tbl[r].e_ao);
         chk($sformatf("row%0d_b_flags_r", r), {if_r.b_full, if_r.b_ovf}, {tbl[r].e_bf, tbl[r].e_bo});
      end
      // Write on a full FIFO in the same cycle it is popped: still dropped.
      a_wr = 1'b1; a_wdata = 8'h77;
      tx_ready = 1'b1;
      tick();
      a_wr = 1'b0;
      chk("fullpop_a_full_l", if_l.a_full, 0);
      chk("fullpop_a_full_r", if_r.a_full, 0);
      chk("fullpop_a_ovf_l", if_l.a_ovf, 1);
      drain("full");

      // Unterminated line from a holds the lock until the timeout.
      do_reset();
      tx_ready = 1'b1;
      push_both(8'h5A, 1'b0);
      push_both(8'h71, 1'b1);
      a_wr = 1'b1; a_wdata = 8'h5A;
      b_wr = 1'b1; b_wdata = 8'h71;
      tick();
      a_wr = 1'b0;
      b_wr = 1'b0;
      cl = -1;
      cr = -1;
      for (int c = 1; c <= 40; c++) begin
         if (cl < 0 && if_l.tx_valid && if_l.tx_data == 8'h71) cl = c;
         if (cr < 0 && if_r.tx_valid && if_r.tx_data == 8'h71) cr = c;
         tick();
      end
      chk("timeout_q_cycle_l", cl, 11);
      chk("rr_q_cycle_r", cr, 3);
      drain("timeout");

      // Reset while a byte is held and both FIFOs have data.
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         a_wr = 1'b1; a_wdata = 8'(8'h30 + i);
         b_wr = (i < 3); b_wdata = 8'(8'h60 + i);
         tick();
      end
      a_wr = 1'b0;
      b_wr = 1'b0;
      tick();
      chk("pre_valid_l", if_l.tx_valid, 1);
      chk("pre_afull_ovf_l", {if_l.a_full, if_l.a_ovf}, 2'b11);
      chk("pre_afull_ovf_r", {if_r.a_full, if_r.a_ovf}, 2'b11);
      do_reset();
      chk("post_valid_l", if_l.tx_valid, 0);
      chk("post_valid_r", if_r.tx_valid, 0);
      chk("post_flags_l", {if_l.a_full, if_l.a_ovf, if_l.b_full, if_l.b_ovf}, 0);
      chk("post_flags_r", {if_r.a_full, if_r.a_ovf, if_r.b_full, if_r.b_ovf}, 0);
      chk("post_data_src_l", {if_l.tx_data, if_l.tx_src}, 0);
      tx_ready = 1'b1;
      repeat (30) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single SoC UART transmitter between the two harts (port a, port b) of the dual-issue torv32 SoC.
- Each hart has its own small byte FIFO, written from its IO store path (IO word address bit 1).
- A round-robin arbiter with optional per-line locking drains both FIFOs into one valid/ready byte stream that feeds corescore_emitter_uart.
- Per-hart full flags go back to each hart's IO read data (bit 9).

Parameters:
- DEPTH, 16: per-hart FIFO depth in bytes; power of two, minimum 2.
- LINE_LOCK, 1: 1 = once a hart is granted, it keeps the grant until it sends 0x0A or times out; 0 = pure byte-level round robin.
- LOCK_TIMEOUT, 1024: cycles a locked hart's FIFO may stay empty before the lock is released; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_wr  in  1  hart a byte write strobe, one cycle per byte
- a_wdata  in  8  hart a byte
- a_full  out  1  hart a FIFO full
- a_ovf  out  1  sticky: hart a wrote while full
- b_wr  in  1  hart b byte write strobe
- b_wdata  in  8  hart b byte
- b_full  out  1  hart b FIFO full
- b_ovf  out  1  sticky: hart b wrote while full
- tx_valid  out  1  output byte valid (drives UART i_valid)
- tx_data  out  8  output byte (drives UART i_data)
- tx_ready  in  1  sink ready (UART o_ready)
- tx_src  out  1  source of the current tx_data: 0 = a, 1 = b

Behaviour:
- Reset is sampled only on a rising clk edge. It clears both FIFOs (pointers and counts), the output register, the FSM (to IDLE), the timeout counter and the round-robin pointer (next preference = a).
- Output values on reset: a_full=b_full=0, a_ovf=b_ovf=0, tx_valid=0, tx_data=0, tx_src=0.
- Reset asserted mid-transfer drops the in-flight byte; the UART is reset by the same signal.

FIFOs:
- Counter width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- x_full = (count == DEPTH). It is a registered view of the count, so it updates the cycle after a push or pop.
- A write while full is dropped and sets x_ovf; x_ovf stays set until reset.
- Full is evaluated before a same-cycle pop, so a write on a full FIFO is dropped even if that FIFO is popped in the same cycle.
- A write on an empty FIFO is not bypassed to the output stage.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged.
- Writes from the two harts are fully independent and may occur in the same cycle.

Output stage:
- A single output register holds tx_valid, tx_data and tx_src.
- A transfer occurs when tx_valid && tx_ready. tx_data and tx_src hold stable until the transfer.
- The register loads (pop plus arbitration decision) when tx_valid==0, or when a transfer occurs in that same cycle. This gives back-to-back throughput of one byte per cycle when tx_ready stays high.
- Latency: a_wr in cycle 0 gives tx_valid=1 in cycle 2, provided the arbiter picks a.

Arbiter FSM (states IDLE, LOCK_A, LOCK_B):
- IDLE, exactly one FIFO non-empty: grant that FIFO.
- IDLE, both non-empty: grant the preferred hart. The pointer then flips to prefer the other hart.
- IDLE with LINE_LOCK=1: granting a byte other than 0x0A moves to LOCK_x for that hart. Granting 0x0A stays in IDLE.
- LOCK_x: only hart x's FIFO is popped. Loading 0x0A from x returns to IDLE and sets the preference to the other hart.
- LOCK_x timeout counter:
  - cleared on entry to LOCK_x, and whenever x's FIFO is non-empty;
  - otherwise increments each cycle;
  - on reaching LOCK_TIMEOUT-1, returns to IDLE next cycle and sets the preference to the other hart.
- LINE_LOCK=0: the FSM never leaves IDLE.
- The counter saturates and never wraps.

Test Plan:
- Reset, then hart a writes 0x41 in cycle 0, tx_ready=1 -> tx_valid=1, tx_data=0x41, tx_src=0 in cycle 2; a single transfer; tx_valid=0 in cycle 3.
- LINE_LOCK=1; a writes "AB\n" and b writes "xy\n", both starting in cycle 0; tx_ready stalls 3 cycles per byte -> output sequence is 41 42 0A 78 79 0A, tx_data stable during stalls, no interleaving.
- LINE_LOCK=0, same stimulus -> output sequence is 41 78 42 79 0A 0A.
- tx_ready=0; a writes DEPTH+1 bytes -> a_full=1 after the 16th byte (cycle after the push), the 17th byte is dropped, a_ovf=1; b is unaffected with b_full=0 and b_ovf=0.
- LINE_LOCK=1, LOCK_TIMEOUT=8; a sends "Z" (no newline) while b has "q" queued -> 'Z' is sent, then after 8 empty cycles the lock releases and 'q' is sent with tx_src=1.
- Reset pulsed while tx_valid=1 and both FIFOs hold data -> the next cycle shows tx_valid=0, a_full=b_full=0, a_ovf=b_ovf=0, and no stale bytes are ever emitted.
